// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready handshake and a stored carry flag for ADC/SBB chaining.
// Define ALU_ROTATE_EN to enable ROL/ROR (opcodes 1100/1101); otherwise those opcodes are illegal.
module alu_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_ADC  = 4'b1000;
  localparam logic [3:0] OP_SBB  = 4'b1001;
  localparam logic [3:0] OP_SAR  = 4'b1010;
  localparam logic [3:0] OP_PASS = 4'b1011;
`ifdef ALU_ROTATE_EN
  localparam logic [3:0] OP_ROL  = 4'b1100;
  localparam logic [3:0] OP_ROR  = 4'b1101;
`endif

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, neg_q;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic             cf_q;
  logic             cf_upd;

  logic             accept;
  logic [SHW-1:0]   n;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             ovf_arith;
  logic [WIDTH:0]   shl_w, shr_w, sar_w;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign n        = b[SHW-1:0];

  // One adder serves ADD/SUB/ADC/SBB; subtraction is a + ~b + carry-in.
  assign b_eff = (op == OP_SUB || op == OP_SBB) ? ~b : b;
  assign cin   = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC || op == OP_SBB) ? cf_q : 1'b0);
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
  assign ovf_arith = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  // The extra bit of each shift vector catches the last bit shifted out.
  assign shl_w = {1'b0, a} << n;
  assign shr_w = {a, 1'b0} >> n;
  assign sar_w = $signed({a, 1'b0}) >>> n;

`ifdef ALU_ROTATE_EN
  logic [SHW-1:0]   rot_n;
  logic [WIDTH-1:0] rol_r, ror_r;
  assign rot_n = SHW'(32'(n) % WIDTH);
  assign rol_r = (a << rot_n) | (a >> (WIDTH - 32'(rot_n)));
  assign ror_r = (a >> rot_n) | (a << (WIDTH - 32'(rot_n)));
`endif

  always_comb begin
    result_d  = '0;
    carry_d   = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    cf_upd    = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        ovf_d    = ovf_arith;
        cf_upd   = 1'b1;
      end
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_NOT:  result_d = ~a;
      OP_PASS: result_d = b;
      OP_SHL: begin
        result_d = shl_w[WIDTH-1:0];
        carry_d  = shl_w[WIDTH];
        cf_upd   = 1'b1;
      end
      OP_SHR: begin
        result_d = shr_w[WIDTH:1];
        carry_d  = shr_w[0];
        cf_upd   = 1'b1;
      end
      OP_SAR: begin
        result_d = sar_w[WIDTH:1];
        carry_d  = sar_w[0];
        cf_upd   = 1'b1;
      end
`ifdef ALU_ROTATE_EN
      OP_ROL: begin
        result_d = rol_r;
        carry_d  = (n != '0) && rol_r[0];
      end
      OP_ROR: begin
        result_d = ror_r;
        carry_d  = (n != '0) && ror_r[WIDTH-1];
      end
`endif
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      cf_q        <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= (result_d == '0);
      neg_q       <= result_d[WIDTH-1];
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      if (cf_upd) cf_q <= carry_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed vectors push expectations, a negedge monitor pops them.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [3:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry, zero, neg, ovf, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       c, z, n, v, il;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Packed fields compared: {result, carry, zero, neg, ovf, illegal}
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.tag, {result, carry, zero, neg, ovf, illegal},
            {mon_e.res, mon_e.c, mon_e.z, mon_e.n, mon_e.v, mon_e.il});
      end
    end
  end

  task automatic send(input string tag, input logic [3:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic [7:0] r, input logic c, input logic z, input logic n,
                      input logic v, input logic il);
    exp_t e;
    int k;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: in_ready stuck at 0, expected 1 within 20 cycles", tag);
    end else begin
      e.tag = tag; e.res = r; e.c = c; e.z = z; e.n = n; e.v = v; e.il = il;
      sb.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input string tag, input logic [7:0] r, input logic c, input logic z,
                          input logic n, input logic v, input logic il);
    exp_t e;
    e.tag = tag; e.res = r; e.c = c; e.z = z; e.n = n; e.v = v; e.il = il;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 4'h0; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {out_valid, result, carry, zero, neg, ovf, illegal}, 32'h0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    //         tag        op     a      b      res    c  z  n  v  il
    send("add_ff_01",   4'h0, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 0);
    send("adc_cf1",     4'h8, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0);
    send("sub_80_01",   4'h1, 8'h80, 8'h01, 8'h7F, 1, 0, 0, 1, 0);
    send("sbb_05_05",   4'h9, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 0);
    send("illegal_e",   4'hE, 8'h12, 8'h34, 8'h00, 0, 1, 0, 0, 1);
    send("adc_keep_cf", 4'h8, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0);
    send("shl_81_1",    4'h6, 8'h81, 8'h01, 8'h02, 1, 0, 0, 0, 0);
    send("sar_81_3",    4'hA, 8'h81, 8'h03, 8'hF0, 0, 0, 1, 0, 0);
    send("shr_81_0",    4'h7, 8'h81, 8'h00, 8'h81, 0, 0, 1, 0, 0);
    send("add_7f_01",   4'h0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 0);
    send("and",         4'h2, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 0);
    send("or",          4'h3, 8'hF0, 8'h0F, 8'hFF, 0, 0, 1, 0, 0);
    send("xor",         4'h4, 8'hFF, 8'h0F, 8'hF0, 0, 0, 1, 0, 0);
    send("not",         4'h5, 8'h0F, 8'h99, 8'hF0, 0, 0, 1, 0, 0);
    send("pass",        4'hB, 8'h11, 8'h5A, 8'h5A, 0, 0, 0, 0, 0);
    send("sub_05_03",   4'h1, 8'h05, 8'h03, 8'h02, 1, 0, 0, 0, 0);
`ifdef ALU_ROTATE_EN
    send("rol_81_1",    4'hC, 8'h81, 8'h01, 8'h03, 1, 0, 0, 0, 0);
    send("ror_81_1",    4'hD, 8'h81, 8'h01, 8'hC0, 1, 0, 1, 0, 0);
`else
    send("rol_illegal", 4'hC, 8'h81, 8'h01, 8'h00, 0, 1, 0, 0, 1);
    send("ror_illegal", 4'hD, 8'h81, 8'h01, 8'h00, 0, 1, 0, 0, 1);
`endif
    send("adc_after_rot", 4'h8, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 0);
    send("illegal_f",   4'hF, 8'hAA, 8'h55, 8'h00, 0, 1, 0, 0, 1);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Stall: A is held for three cycles while B waits at the input.
    send("stall_a", 4'h0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0, 0);
    op = 4'h0; a = 8'h01; b = 8'h02; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", {out_valid, result, carry, zero, neg, ovf, illegal}, {1'b1, 8'h30, 5'b00000});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_exp("stall_b", 8'h03, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    op = 4'h0; a = 8'h03; b = 8'h04;
    push_exp("stall_c", 8'h07, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("no_bubble_b", {out_valid, result}, {1'b1, 8'h03});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_c", {out_valid, result}, {1'b1, 8'h07});
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_valid", out_valid, 0);
    @(posedge clk); #1;

    // Reset while stalled: pending result and cf=1 must both be discarded.
    send("rst_pending", 4'h0, 8'hFF, 8'h02, 8'h01, 1, 0, 0, 0, 0);
    op = 4'h8; a = 8'h01; b = 8'h01; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midstall_reset_outputs", {out_valid, result, carry, zero, neg, ovf, illegal}, 32'h0);
    chk("midstall_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    send("adc_after_rst", 4'h8, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 0);
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
